// File: rtl/vram_arbiter.sv
// Time-slotted VRAM arbiter: an 8-phase frame that shares one SRAM between video, CPU and DMA.
// Optional DMA port enabled by defining VRAM_ARBITER_DMA_EN.
module vram_arbiter #(
  parameter int VID_EN_PHASE = 0,
  parameter int CPU_PHASE    = 4
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        phase_sync,
  input  logic        video_req,
  input  logic [18:0] video_addr,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic [7:0]  vd_in,
  output logic [18:0] va,
  output logic [7:0]  vd_out,
  output logic        vd_oe,
  output logic        n_vwr,
  output logic        screen_fetch,
  output logic [7:0]  video_data,
  output logic        video_valid,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_valid,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack
);

  localparam logic [2:0] VID_PH = 3'(VID_EN_PHASE);
  localparam logic [2:0] CPU_PH = 3'(CPU_PHASE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VID,
`ifdef VRAM_ARBITER_DMA_EN
    S_CPU,
    S_DMA
`else
    S_CPU
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        sub_q, sub_d;           // 0 = sub-cycle A, 1 = sub-cycle B
  logic        wr_q, wr_d;
  logic [2:0]  phase_q, phase_d;
  logic [18:0] va_q, va_d;
  logic [7:0]  vd_out_q, vd_out_d;
  logic        vd_oe_q, vd_oe_d;
  logic        n_vwr_q, n_vwr_d;
  logic        sf_q, sf_d;
  logic [7:0]  video_data_q, video_data_d;
  logic        video_valid_q, video_valid_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_valid_q, cpu_valid_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;
  logic        dma_ack_q, dma_ack_d;
  logic        slot_end;

  always_comb begin
    state_d       = state_q;
    sub_d         = sub_q;
    wr_d          = wr_q;
    va_d          = va_q;
    vd_out_d      = vd_out_q;
    video_data_d  = video_data_q;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    video_valid_d = 1'b0;
    cpu_valid_d   = 1'b0;
    dma_ack_d     = 1'b0;
    phase_d       = phase_sync ? 3'd0 : phase_q + 3'd1;
    slot_end      = (state_q != S_IDLE) && sub_q;

    if (slot_end) begin
      case (state_q)
        S_VID: begin
          video_valid_d = 1'b1;
          video_data_d  = vd_in;
        end
        S_CPU: if (!wr_q) begin
          cpu_valid_d = 1'b1;
          cpu_rdata_d = vd_in;
        end
`ifdef VRAM_ARBITER_DMA_EN
        S_DMA: begin
          dma_ack_d = 1'b1;
          if (!wr_q) dma_rdata_d = vd_in;
        end
`endif
        default: ;
      endcase
    end

    // Grants are decided one cycle ahead so sub-cycle A lands exactly on the even phase.
    if (state_q != S_IDLE && !sub_q) begin
      sub_d = 1'b1;
    end else begin
      state_d = S_IDLE;
      sub_d   = 1'b0;
      wr_d    = 1'b0;
      if (!phase_d[0]) begin
        if (phase_d == VID_PH && video_req) begin
          state_d = S_VID;
          va_d    = video_addr;
        end else if (phase_d == CPU_PH && cpu_req) begin
          state_d  = S_CPU;
          wr_d     = cpu_wr;
          va_d     = cpu_addr;
          vd_out_d = cpu_wdata;
        end
`ifdef VRAM_ARBITER_DMA_EN
        // No back-to-back DMA: the requester has not yet seen the ack of the slot ending now.
        else if (dma_req && state_q != S_DMA) begin
          state_d  = S_DMA;
          wr_d     = dma_wr;
          va_d     = dma_addr;
          vd_out_d = dma_wdata;
        end
`endif
      end
    end

`ifdef VRAM_ARBITER_DMA_EN
    vd_oe_d = (state_d == S_CPU || state_d == S_DMA) && wr_d;
`else
    vd_oe_d = (state_d == S_CPU) && wr_d;
`endif
    n_vwr_d = !(vd_oe_d && sub_d);
    sf_d    = (state_d == S_VID);
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sub_q         <= 1'b0;
      wr_q          <= 1'b0;
      phase_q       <= 3'd0;
      va_q          <= '0;
      vd_out_q      <= '0;
      vd_oe_q       <= 1'b0;
      n_vwr_q       <= 1'b1;
      sf_q          <= 1'b0;
      video_data_q  <= '0;
      video_valid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_valid_q   <= 1'b0;
      dma_rdata_q   <= '0;
      dma_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sub_q         <= sub_d;
      wr_q          <= wr_d;
      phase_q       <= phase_d;
      va_q          <= va_d;
      vd_out_q      <= vd_out_d;
      vd_oe_q       <= vd_oe_d;
      n_vwr_q       <= n_vwr_d;
      sf_q          <= sf_d;
      video_data_q  <= video_data_d;
      video_valid_q <= video_valid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_valid_q   <= cpu_valid_d;
      dma_rdata_q   <= dma_rdata_d;
      dma_ack_q     <= dma_ack_d;
    end
  end

  assign va           = va_q;
  assign vd_out       = vd_out_q;
  assign vd_oe        = vd_oe_q;
  assign n_vwr        = n_vwr_q;
  assign screen_fetch = sf_q;
  assign video_data   = video_data_q;
  assign video_valid  = video_valid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_valid    = cpu_valid_q;

`ifdef VRAM_ARBITER_DMA_EN
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
`else
  assign dma_rdata = 8'h00;
  assign dma_ack   = 1'b0;
  wire unused_dma = ^{dma_req, dma_wr, dma_addr, dma_wdata, dma_rdata_q, dma_ack_q};
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed frame tables, corner sequences, and random traffic
// checked every cycle against a slot-level reference model.
module tb_vram_arbiter;

  localparam int VID = 0;
  localparam int CPU = 4;
`ifdef VRAM_ARBITER_DMA_EN
  localparam bit DMA_ON = 1'b1;
`else
  localparam bit DMA_ON = 1'b0;
`endif

  logic        clk28, rst, phase_sync;
  logic        video_req, cpu_req, cpu_wr, dma_req, dma_wr;
  logic [18:0] video_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, vd_in;
  logic [18:0] va;
  logic [7:0]  vd_out, video_data, cpu_rdata, dma_rdata;
  logic        vd_oe, n_vwr, screen_fetch, video_valid, cpu_valid, dma_ack;

  vram_arbiter #(.VID_EN_PHASE(VID), .CPU_PHASE(CPU)) dut (
    .clk28(clk28), .rst(rst), .phase_sync(phase_sync),
    .video_req(video_req), .video_addr(video_addr),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .vd_in(vd_in), .va(va), .vd_out(vd_out), .vd_oe(vd_oe), .n_vwr(n_vwr),
    .screen_fetch(screen_fetch), .video_data(video_data), .video_valid(video_valid),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .dma_rdata(dma_rdata), .dma_ack(dma_ack)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk28);
    @(negedge clk28);
  endtask

  // Slot-level model: owner of the bus plus cycles left in its 2-cycle slot.
  typedef struct {
    int          ph, owner, left;   // owner: 0 none, 1 video, 2 cpu, 3 dma
    bit          wr;
    logic [18:0] va;
    logic [7:0]  vdo, vdata, cdata, ddata;
    bit          oe, nwr, sf, vv, cv, dack;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c);
    model_t n;
    int nph, nw;
    bit in_b;
    n = c;
    if (rst) begin
      n = '{default: 0};
      n.nwr = 1'b1;
      return n;
    end
    in_b = (c.left == 1);
    n.vv = 0; n.cv = 0; n.dack = 0;
    if (in_b) begin
      if (c.owner == 1) begin n.vv = 1; n.vdata = vd_in; end
      else if (c.owner == 2 && !c.wr) begin n.cv = 1; n.cdata = vd_in; end
      else if (c.owner == 3) begin n.dack = 1; if (!c.wr) n.ddata = vd_in; end
    end
    nph = phase_sync ? 0 : (c.ph + 1) % 8;
    nw = 0;
    if (c.left <= 1 && nph % 2 == 0) begin
      if (nph == VID && video_req) nw = 1;
      else if (nph == CPU && cpu_req) nw = 2;
      else if (DMA_ON && dma_req && !(in_b && c.owner == 3)) nw = 3;
    end
    case (nw)
      1: begin n.va = video_addr; n.wr = 0; end
      2: begin n.va = cpu_addr; n.vdo = cpu_wdata; n.wr = cpu_wr; end
      3: begin n.va = dma_addr; n.vdo = dma_wdata; n.wr = dma_wr; end
      default: ;
    endcase
    if (nw != 0) begin
      n.owner = nw; n.left = 2;
    end else if (c.left > 0) begin
      n.left = c.left - 1;
      if (n.left == 0) begin n.owner = 0; n.wr = 0; end
    end
    n.ph  = nph;
    n.sf  = (n.left > 0) && (n.owner == 1);
    n.oe  = (n.left > 0) && (n.owner >= 2) && n.wr;
    n.nwr = !(n.oe && n.left == 1);
    return n;
  endfunction

  always @(posedge clk28) m <= step(m);

  always @(negedge clk28) begin
    if (chk_en) begin
      check("va", 32'(va), 32'(m.va));
      check("vd_out", 32'(vd_out), 32'(m.vdo));
      check("vd_oe", 32'(vd_oe), 32'(m.oe));
      check("n_vwr", 32'(n_vwr), 32'(m.nwr));
      check("screen_fetch", 32'(screen_fetch), 32'(m.sf));
      check("video_valid", 32'(video_valid), 32'(m.vv));
      check("video_data", 32'(video_data), 32'(m.vdata));
      check("cpu_valid", 32'(cpu_valid), 32'(m.cv));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m.cdata));
      check("dma_ack", 32'(dma_ack), 32'(m.dack));
      check("dma_rdata", 32'(dma_rdata), 32'(m.ddata));
    end
  end

  // Per-phase expectations over the second frame after reset; bit p = phase p.
  typedef struct {
    logic        vreq, creq, cwr;
    logic [18:0] caddr;
    logic [7:0]  cwd;
    logic [7:0]  sf, oe, nwl, vv, cv;
    logic [18:0] va0, va4;
    logic [7:0]  vdo4;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int p, input string name);
    int n;
    n = 0;
    while (m.ph != p && n < 20) begin tick(); n++; end
    check({name, "_wait"}, 32'(m.ph == p), 32'd1);
  endtask

  initial begin
    rst = 1'b1; phase_sync = 0; video_req = 0; cpu_req = 0; cpu_wr = 0;
    dma_req = 0; dma_wr = 0; video_addr = 19'h7C000; cpu_addr = 0; dma_addr = 0;
    cpu_wdata = 0; dma_wdata = 0; vd_in = 8'h5A;

    vecs[0] = '{1, 0, 0, 19'h00000, 8'h00, 8'h03, 8'h00, 8'h00, 8'h04, 8'h00, 19'h7C000, 19'h7C000, 8'h00};
    vecs[1] = '{0, 1, 1, 19'h12345, 8'hA5, 8'h00, 8'h30, 8'h20, 8'h00, 8'h00, 19'h12345, 19'h12345, 8'hA5};
    vecs[2] = '{0, 1, 0, 19'h0ABCD, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 19'h0ABCD, 19'h0ABCD, 8'h3C};
    vecs[3] = '{1, 1, 1, 19'h12345, 8'hA5, 8'h03, 8'h30, 8'h20, 8'h04, 8'h00, 19'h7C000, 19'h12345, 8'hA5};
    vecs[4] = '{0, 0, 0, 19'h12345, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 19'h00000, 19'h00000, 8'h00};
    vecs[5] = '{1, 1, 0, 19'h0ABCD, 8'h3C, 8'h03, 8'h00, 8'h00, 8'h04, 8'h40, 19'h7C000, 19'h0ABCD, 8'h3C};

    tick(); tick();
    // Reset state
    check("rst_n_vwr", 32'(n_vwr), 32'd1);
    check("rst_va", 32'(va), 32'd0);
    check("rst_vd_oe", 32'(vd_oe), 32'd0);
    check("rst_screen_fetch", 32'(screen_fetch), 32'd0);
    chk_en = 1'b1;

    foreach (vecs[i]) begin
      video_req = vecs[i].vreq; cpu_req = vecs[i].creq; cpu_wr = vecs[i].cwr;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd; vd_in = 8'h5A;
      do_reset();
      repeat (7) tick();
      for (int p = 0; p < 8; p++) begin
        tick();
        check($sformatf("v%0d_sf_p%0d", i, p), 32'(screen_fetch), 32'(vecs[i].sf[p]));
        check($sformatf("v%0d_oe_p%0d", i, p), 32'(vd_oe), 32'(vecs[i].oe[p]));
        check($sformatf("v%0d_nwr_p%0d", i, p), 32'(n_vwr), 32'(!vecs[i].nwl[p]));
        check($sformatf("v%0d_vv_p%0d", i, p), 32'(video_valid), 32'(vecs[i].vv[p]));
        check($sformatf("v%0d_cv_p%0d", i, p), 32'(cpu_valid), 32'(vecs[i].cv[p]));
        if (p == 0) check($sformatf("v%0d_va_p0", i), 32'(va), 32'(vecs[i].va0));
        if (p == 4) begin
          check($sformatf("v%0d_va_p4", i), 32'(va), 32'(vecs[i].va4));
          check($sformatf("v%0d_vdo_p4", i), 32'(vd_out), 32'(vecs[i].vdo4));
        end
      end
    end

    // Reset during sub-cycle B of a CPU write
    video_req = 0; cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h12345; cpu_wdata = 8'hA5;
    do_reset();
    wait_phase(5, "rstwr");
    check("rstwr_nwr_low", 32'(n_vwr), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; cpu_req = 0;
    check("rstwr_nwr_high", 32'(n_vwr), 32'd1);
    check("rstwr_oe", 32'(vd_oe), 32'd0);
    check("rstwr_cv0", 32'(cpu_valid), 32'd0);
    tick();
    check("rstwr_cv1", 32'(cpu_valid), 32'd0);

    // phase_sync at phase 3 starts a video slot immediately
    video_req = 1; video_addr = 19'h7C000; vd_in = 8'hC3;
    do_reset();
    wait_phase(3, "sync");
    phase_sync = 1;
    tick();
    phase_sync = 0;
    check("sync_sf_a", 32'(screen_fetch), 32'd1);
    check("sync_va", 32'(va), 32'h7C000);
    tick();
    check("sync_sf_b", 32'(screen_fetch), 32'd1);
    tick();
    check("sync_vv", 32'(video_valid), 32'd1);
    check("sync_vdata", 32'(video_data), 32'hC3);
    video_req = 0;

`ifdef VRAM_ARBITER_DMA_EN
    // DMA loses phase 4 to the CPU and takes phase 6
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h01234; dma_wr = 0; dma_addr = 19'h55555;
    do_reset();
    wait_phase(3, "dma");
    dma_req = 1;
    tick();
    check("dma_cpu_first", 32'(va), 32'h01234);
    tick(); tick();
    check("dma_va_p6", 32'(va), 32'h55555);
    tick();
    vd_in = 8'h9E;
    tick();
    check("dma_ack_p0", 32'(dma_ack), 32'd1);
    check("dma_rdata", 32'(dma_rdata), 32'h9E);
    dma_req = 0; cpu_req = 0;
    tick();
    check("dma_ack_once", 32'(dma_ack), 32'd0);
`else
    // DMA port never granted
    dma_req = 1; dma_addr = 19'h55555;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      tick();
      check("nodma_ack", 32'(dma_ack), 32'd0);
      check("nodma_va", 32'(va == 19'h55555), 32'd0);
    end
    dma_req = 0;
`endif

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 149) == 0);
      phase_sync = ($urandom_range(0, 39) == 0);
      video_req  = ($urandom_range(0, 3) != 0);
      video_addr = 19'($urandom);
      cpu_req    = $urandom_range(0, 1);
      cpu_wr     = $urandom_range(0, 1);
      cpu_addr   = 19'($urandom);
      cpu_wdata  = 8'($urandom);
      vd_in      = 8'($urandom);
      if (!dma_req || m.dack || rst) begin
        dma_req   = $urandom_range(0, 1);
        dma_wr    = $urandom_range(0, 1);
        dma_addr  = 19'($urandom);
        dma_wdata = 8'($urandom);
      end
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
